// File: rtl/riscv_core_wb_arb.sv
// Writeback arbiter: the main pipeline has priority on the register-file write port; long-latency
// (mul/div) results wait in a small FIFO. A pending-write bitmap reports decode-stage hazards.
module riscv_core_wb_arb #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          i_wb_clk,
    input  logic                          i_wb_rst,
    input  logic                          i_wb_pipe_we,
    input  logic [4:0]                    i_wb_pipe_rd,
    input  logic [XLEN-1:0]               i_wb_pipe_data,
    input  logic                          i_wb_lu_issue,
    input  logic [4:0]                    i_wb_lu_issue_rd,
    input  logic                          i_wb_lu_valid,
    input  logic [4:0]                    i_wb_lu_rd,
    input  logic [XLEN-1:0]               i_wb_lu_data,
    output logic                          o_wb_lu_ready,
    input  logic [4:0]                    i_wb_rs1,
    input  logic [4:0]                    i_wb_rs2,
    output logic                          o_wb_hazard,
    output logic                          o_wb_rf_we,
    output logic [4:0]                    o_wb_rf_a3,
    output logic [XLEN-1:0]               o_wb_rf_wd,
    output logic [$clog2(FIFO_DEPTH):0]   o_wb_fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pending_q, pending_d;

    logic             push_c;
    logic             pop_c;
    logic [4:0]       head_rd_c;
    logic [XLEN-1:0]  head_data_c;

    assign head_rd_c   = fifo_rd_q[rptr_q];
    assign head_data_c = fifo_data_q[rptr_q];

    // Ready depends on registered occupancy only, so an empty FIFO can never bypass.
    assign o_wb_lu_ready   = (count_q < CNT_W'(FIFO_DEPTH));
    assign push_c          = i_wb_lu_valid && o_wb_lu_ready;
    assign pop_c           = !i_wb_pipe_we && (count_q != '0);
    assign o_wb_hazard     = pending_q[i_wb_rs1] | pending_q[i_wb_rs2];
    assign o_wb_fifo_count = count_q;

    // Write-port select: pipeline first, then FIFO head, else idle zeros.
    always_comb begin
        o_wb_rf_we = 1'b0;
        o_wb_rf_a3 = 5'd0;
        o_wb_rf_wd = '0;
        if (i_wb_pipe_we) begin
            o_wb_rf_we = (i_wb_pipe_rd != 5'd0);
            o_wb_rf_a3 = i_wb_pipe_rd;
            o_wb_rf_wd = i_wb_pipe_data;
        end else if (count_q != '0) begin
            o_wb_rf_we = (head_rd_c != 5'd0);
            o_wb_rf_a3 = head_rd_c;
            o_wb_rf_wd = head_data_c;
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        pending_d = pending_q;
        if (push_c) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + PTR_W'(1);
            pending_d[head_rd_c] = 1'b0;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A same-cycle issue to the retiring rd must leave it pending.
        if (i_wb_lu_issue && (i_wb_lu_issue_rd != 5'd0)) begin
            pending_d[i_wb_lu_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Payload storage needs no reset; occupancy gates every read.
    always_ff @(posedge i_wb_clk) begin
        if (push_c) begin
            fifo_rd_q[wptr_q]   <= i_wb_lu_rd;
            fifo_data_q[wptr_q] <= i_wb_lu_data;
        end
    end

endmodule

// File: tb/tb_riscv_core_wb_arb.sv
// Self-checking bench for riscv_core_wb_arb: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based reference model.
module tb_riscv_core_wb_arb;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            lu_issue;
    logic [4:0]      lu_issue_rd;
    logic            lu_valid;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            lu_ready;
    logic [4:0]      rs1, rs2;
    logic            hazard;
    logic            rf_we;
    logic [4:0]      rf_a3;
    logic [XLEN-1:0] rf_wd;
    logic [1:0]      fifo_count;

    riscv_core_wb_arb #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .i_wb_clk        (clk),
        .i_wb_rst        (rst),
        .i_wb_pipe_we    (pipe_we),
        .i_wb_pipe_rd    (pipe_rd),
        .i_wb_pipe_data  (pipe_data),
        .i_wb_lu_issue   (lu_issue),
        .i_wb_lu_issue_rd(lu_issue_rd),
        .i_wb_lu_valid   (lu_valid),
        .i_wb_lu_rd      (lu_rd),
        .i_wb_lu_data    (lu_data),
        .o_wb_lu_ready   (lu_ready),
        .i_wb_rs1        (rs1),
        .i_wb_rs2        (rs2),
        .o_wb_hazard     (hazard),
        .o_wb_rf_we      (rf_we),
        .o_wb_rf_a3      (rf_a3),
        .o_wb_rf_wd      (rf_wd),
        .o_wb_fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t model_q[$];
    bit     model_pend[32];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [XLEN-1:0] pd,
                         input logic iss, input logic [4:0] ird,
                         input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2);
        pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
        lu_issue = iss; lu_issue_rd = ird;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        rs1 = r1; rs2 = r2;
    endtask

    task automatic model_reset();
        model_q.delete();
        foreach (model_pend[i]) model_pend[i] = 1'b0;
    endtask

    // Check current outputs against the model, clock once, advance the model.
    task automatic step(input string tag, output bit accepted);
        bit              m_ready, m_we, m_pop;
        logic [4:0]      m_a3;
        logic [XLEN-1:0] m_wd;
        entry_t          e;
        #2;
        m_ready = (model_q.size() < DEPTH);
        m_we = 1'b0; m_a3 = '0; m_wd = '0;
        if (pipe_we) begin
            m_we = (pipe_rd != 0); m_a3 = pipe_rd; m_wd = pipe_data;
        end else if (model_q.size() > 0) begin
            m_we = (model_q[0].rd != 0); m_a3 = model_q[0].rd; m_wd = model_q[0].data;
        end
        chk({tag, ".rf_we"}, XLEN'(rf_we), XLEN'(m_we));
        chk({tag, ".rf_a3"}, XLEN'(rf_a3), XLEN'(m_a3));
        chk({tag, ".rf_wd"}, rf_wd, m_wd);
        chk({tag, ".ready"}, XLEN'(lu_ready), XLEN'(m_ready));
        chk({tag, ".hazard"}, XLEN'(hazard), XLEN'(model_pend[rs1] | model_pend[rs2]));
        chk({tag, ".count"}, XLEN'(fifo_count), XLEN'(model_q.size()));
        @(posedge clk);
        m_pop = !pipe_we && (model_q.size() > 0);
        if (m_pop) begin
            e = model_q.pop_front();
            model_pend[e.rd] = 1'b0;
        end
        accepted = lu_valid && m_ready;
        if (accepted) begin
            e.rd = lu_rd; e.data = lu_data;
            model_q.push_back(e);
        end
        if (lu_issue && lu_issue_rd != 0) model_pend[lu_issue_rd] = 1'b1;
        model_pend[0] = 1'b0;
        #1;
    endtask

    typedef struct {
        logic            pwe; logic [4:0] prd; logic [XLEN-1:0] pd;
        logic            iss; logic [4:0] ird;
        logic            lv;  logic [4:0] lrd; logic [XLEN-1:0] ld;
        logic [4:0]      r1, r2;
        logic            e_we; logic [4:0] e_a3; logic [XLEN-1:0] e_wd;
        logic            e_rdy, e_haz; logic [1:0] e_cnt;
    } vec_t;

    vec_t vt[13];

    initial begin
        bit              acc;
        bit              off_v;
        logic [4:0]      off_rd;
        logic [XLEN-1:0] off_d;

        //        pwe prd  pd        iss ird lv lrd  ld       r1 r2  we a3 wd        rdy haz cnt
        vt[0]  = '{1, 5,  64'h1234, 0, 0,  0, 0,  64'h0,   0, 0,  1, 5,  64'h1234, 1, 0, 0};
        vt[1]  = '{1, 3,  64'h11,   1, 7,  0, 0,  64'h0,   0, 0,  1, 3,  64'h11,   1, 0, 0};
        vt[2]  = '{1, 3,  64'h22,   0, 0,  1, 7,  64'hAA,  7, 0,  1, 3,  64'h22,   1, 1, 0};
        vt[3]  = '{1, 4,  64'h33,   0, 0,  0, 0,  64'h0,   7, 0,  1, 4,  64'h33,   1, 1, 1};
        vt[4]  = '{0, 0,  64'h0,    0, 0,  0, 0,  64'h0,   7, 0,  1, 7,  64'hAA,   1, 1, 1};
        vt[5]  = '{0, 0,  64'h0,    0, 0,  0, 0,  64'h0,   7, 0,  0, 0,  64'h0,    1, 0, 0};
        vt[6]  = '{0, 0,  64'h0,    1, 0,  1, 0,  64'h55,  0, 0,  0, 0,  64'h0,    1, 0, 0};
        vt[7]  = '{0, 0,  64'h0,    0, 0,  0, 0,  64'h0,   0, 0,  0, 0,  64'h55,   1, 0, 1};
        vt[8]  = '{0, 0,  64'h0,    0, 0,  0, 0,  64'h0,   0, 0,  0, 0,  64'h0,    1, 0, 0};
        vt[9]  = '{0, 0,  64'h0,    1, 9,  0, 0,  64'h0,   0, 0,  0, 0,  64'h0,    1, 0, 0};
        vt[10] = '{1, 1,  64'h1,    0, 0,  1, 9,  64'h99,  9, 0,  1, 1,  64'h1,    1, 1, 0};
        vt[11] = '{0, 0,  64'h0,    1, 9,  0, 0,  64'h0,   0, 9,  1, 9,  64'h99,   1, 1, 1};
        vt[12] = '{0, 0,  64'h0,    0, 0,  0, 0,  64'h0,   9, 0,  0, 0,  64'h0,    1, 1, 0};

        rst = 1'b1;
        drive(1, 5'd6, 64'hBEEF, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("reset.count", XLEN'(fifo_count), 0);
        chk("reset.ready", XLEN'(lu_ready), 1);
        chk("reset.hazard", XLEN'(hazard), 0);
        chk("reset.pipe_we", XLEN'(rf_we), 1);
        chk("reset.pipe_a3", XLEN'(rf_a3), 6);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: idle path, priority, x0 handling, same-cycle set/clear.
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].pwe, vt[i].prd, vt[i].pd, vt[i].iss, vt[i].ird,
                  vt[i].lv, vt[i].lrd, vt[i].ld, vt[i].r1, vt[i].r2);
            #2;
            chk($sformatf("vt%0d.we", i),  XLEN'(rf_we), XLEN'(vt[i].e_we));
            chk($sformatf("vt%0d.a3", i),  XLEN'(rf_a3), XLEN'(vt[i].e_a3));
            chk($sformatf("vt%0d.wd", i),  rf_wd, vt[i].e_wd);
            chk($sformatf("vt%0d.rdy", i), XLEN'(lu_ready), XLEN'(vt[i].e_rdy));
            chk($sformatf("vt%0d.haz", i), XLEN'(hazard), XLEN'(vt[i].e_haz));
            chk($sformatf("vt%0d.cnt", i), XLEN'(fifo_count), XLEN'(vt[i].e_cnt));
            #(-2 + 2);
            step($sformatf("vt%0d.m", i), acc);
        end

        // Full backpressure with pipe held busy, then drain in order.
        drive(1, 2, 64'h2, 0, 0, 1, 10, 64'hA0, 0, 0); step("bp0", acc);
        drive(1, 2, 64'h2, 0, 0, 1, 11, 64'hB0, 0, 0); step("bp1", acc);
        drive(1, 2, 64'h2, 0, 0, 1, 12, 64'hC0, 0, 0);
        #2; chk("bp2.ready_low", XLEN'(lu_ready), 0); chk("bp2.count_full", XLEN'(fifo_count), 2);
        step("bp2", acc);
        chk("bp2.not_accepted", XLEN'(acc), 0);
        drive(0, 0, 0, 0, 0, 1, 12, 64'hC0, 0, 0);
        #2; chk("bp3.first_a3", XLEN'(rf_a3), 10);
        step("bp3", acc);
        drive(0, 0, 0, 0, 0, 1, 12, 64'hC0, 0, 0);
        #2; chk("bp4.second_a3", XLEN'(rf_a3), 11);
        step("bp4", acc);
        chk("bp4.third_accepted", XLEN'(acc), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("bp5", acc);
        step("bp6", acc);

        // Asynchronous reset mid-cycle with a full FIFO and pending writes.
        drive(1, 2, 64'h2, 1, 13, 1, 14, 64'hD0, 13, 0); step("ar0", acc);
        drive(1, 2, 64'h2, 0, 0, 1, 15, 64'hE0, 13, 0); step("ar1", acc);
        drive(1, 2, 64'h2, 0, 0, 0, 0, 0, 13, 0);
        #2;
        chk("ar.pre_count", XLEN'(fifo_count), 2);
        chk("ar.pre_hazard", XLEN'(hazard), 1);
        rst = 1'b1;
        #1;
        chk("ar.count", XLEN'(fifo_count), 0);
        chk("ar.ready", XLEN'(lu_ready), 1);
        chk("ar.hazard", XLEN'(hazard), 0);
        chk("ar.pipe_we", XLEN'(rf_we), 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic; an offered result is held until accepted.
        off_v = 1'b0; off_rd = '0; off_d = '0;
        for (int c = 0; c < 500; c++) begin
            if (!off_v && ($urandom_range(0, 2) != 0)) begin
                off_v  = 1'b1;
                off_rd = 5'($urandom_range(0, 31));
                off_d  = {32'($urandom), 32'($urandom)};
            end
            drive(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), {32'($urandom), 32'($urandom)},
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                  off_v, off_rd, off_d,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step("rnd", acc);
            if (acc) off_v = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/riscv_core_wb_arb.md
RISCV_CORE_WB_ARB -- requirements
Module: riscv_core_wb_arb

Interface
REQ-001 SHALL have parameter XLEN, default 64: register data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: long-latency result buffer entries, power of two and at least 2.
REQ-003 SHALL have port i_wb_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_wb_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_wb_pipe_we, input, 1 bit: main pipeline writeback request.
REQ-006 SHALL have port i_wb_pipe_rd, input, 5 bits: main pipeline destination register.
REQ-007 SHALL have port i_wb_pipe_data, input, XLEN bits: main pipeline write data.
REQ-008 SHALL have port i_wb_lu_issue, input, 1 bit: a long-latency (mul/div) op issued this cycle.
REQ-009 SHALL have port i_wb_lu_issue_rd, input, 5 bits: destination of the issued long-latency op.
REQ-010 SHALL have port i_wb_lu_valid, input, 1 bit: long-latency result offered.
REQ-011 SHALL have port i_wb_lu_rd, input, 5 bits: destination of the offered result.
REQ-012 SHALL have port i_wb_lu_data, input, XLEN bits: data of the offered result.
REQ-013 SHALL have port o_wb_lu_ready, output, 1 bit: buffer accepts the result this cycle.
REQ-014 SHALL have port i_wb_rs1, input, 5 bits: decode-stage source register 1 for hazard query.
REQ-015 SHALL have port i_wb_rs2, input, 5 bits: decode-stage source register 2 for hazard query.
REQ-016 SHALL have port o_wb_hazard, output, 1 bit: a queried source has a pending long-latency write.
REQ-017 SHALL have port o_wb_rf_we, output, 1 bit: register file write enable.
REQ-018 SHALL have port o_wb_rf_a3, output, 5 bits: register file write address.
REQ-019 SHALL have port o_wb_rf_wd, output, XLEN bits: register file write data.
REQ-020 SHALL have port o_wb_fifo_count, output, log2(FIFO_DEPTH)+1 bits: buffer occupancy.

Function
REQ-021 SHALL hold a FIFO_DEPTH-entry FIFO of {rd, data} with wrapping read/write pointers and occupancy count.
REQ-022 SHALL drive o_wb_lu_ready = (count < FIFO_DEPTH), registered-state only, independent of a same-cycle pop.
REQ-023 SHALL push when i_wb_lu_valid && o_wb_lu_ready; the result is held by the source while valid && !ready.
REQ-024 SHALL give the main pipeline absolute priority: when i_wb_pipe_we=1, the RF outputs carry the pipe rd/data and no pop occurs.
REQ-025 SHALL pop the FIFO head when i_wb_pipe_we=0 and count>0; the RF outputs carry head rd/data in that same cycle (combinational select, zero added latency).
REQ-026 SHALL force o_wb_rf_we=0 whenever the selected rd is 0; a FIFO head with rd=0 still pops.
REQ-027 SHALL drive o_wb_rf_a3=0 and o_wb_rf_wd=0 when no source is selected.
REQ-028 SHALL apply simultaneous push and pop: count unchanged, both pointers advance; an empty FIFO never bypasses (a push lands first, pops no earlier than the next cycle).
REQ-029 SHALL keep a 32-bit pending bitmap: set bit rd on i_wb_lu_issue with rd≠0, clear bit rd on pop of that rd.
REQ-030 SHALL let set win when issue and pop target the same rd in one cycle.
REQ-031 SHALL keep bit 0 permanently 0.
REQ-032 SHALL drive o_wb_hazard = pending[i_wb_rs1] | pending[i_wb_rs2], combinational from the registered bitmap.

Reset
REQ-033 SHALL, on i_wb_rst=1 (asynchronous) and at any point mid-operation, clear pointers, count and pending bitmap; o_wb_lu_ready=1, o_wb_hazard=0, o_wb_rf_we=0 unless i_wb_pipe_we=1, o_wb_fifo_count=0; FIFO data contents are don't-care.
REQ-034 SHALL treat the pipe path as purely combinational, passing through during reset.

Verification
REQ-035 SHALL cover the idle path: pipe_we=1, rd=5, data=0x1234 with FIFO empty -> rf_we=1, a3=5, wd=0x1234 in the same cycle.
REQ-036 SHALL cover priority: issue rd=7; lu result rd=7, data=0xAA while pipe_we=1 for 3 cycles -> count=1, hazard(rs1=7)=1; first pipe-idle cycle -> a3=7, wd=0xAA, count=0, hazard=0 the next cycle.
REQ-037 SHALL cover full backpressure: pipe_we held 1 and 3 results offered -> ready=0 after 2 pushes with count=2; release pipe -> pops in order over 2 cycles, then the third result is accepted.
REQ-038 SHALL cover x0: issue rd=0 -> bitmap unchanged; lu result rd=0 -> pops with rf_we=0.
REQ-039 SHALL cover same-cycle set/clear: pop of rd=9 while issue rd=9 -> pending[9] stays 1.
REQ-040 SHALL cover async reset: assert rst mid-cycle with count=2 and pending nonzero -> count=0, ready=1, hazard=0 immediately, without waiting for a clock edge.
